// File: rtl/fpu_issue_seq.sv
// Issue sequencer for the shared FPU: accepts one decoded op at a time, times
// fixed-latency ops locally, waits on unit_done for div/sqrt, then holds writeback.
module fpu_issue_seq #(
  parameter int FPU_OP_LEN = 6,
  parameter int ADD_LAT    = 3,
  parameter int MUL_LAT    = 4,
  parameter int CVT_LAT    = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FPU_OP_LEN-1:0] in_op,
  input  logic [4:0]            in_rd,
  input  logic                  in_rd_fp,
  input  logic                  flush,
  output logic                  start,
  output logic [FPU_OP_LEN-1:0] start_op,
  input  logic                  unit_done,
  output logic                  kill,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [4:0]            wb_rd,
  output logic                  wb_fp,
  output logic                  wb_err,
  output logic                  illegal,
  output logic                  busy
);

  localparam int CNT_W = $clog2(TIMEOUT + ADD_LAT + MUL_LAT + CVT_LAT + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [2:0] C_SINGLE = 3'd0;
  localparam logic [2:0] C_ADD    = 3'd1;
  localparam logic [2:0] C_MUL    = 3'd2;
  localparam logic [2:0] C_CVT    = 3'd3;
  localparam logic [2:0] C_ITER   = 3'd4;
  localparam logic [2:0] C_MEM    = 3'd5;
  localparam logic [2:0] C_ILL    = 3'd6;

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [FPU_OP_LEN-1:0] r_op;
  logic [4:0]            r_rd;
  logic                  r_fp;
  logic                  r_err;
  logic                  r_iter;
  logic                  r_start;
  logic                  r_kill;
  logic                  r_illegal;

  logic [2:0]            w_class;
  logic                  w_accept;
  logic                  w_exec;
  logic [CNT_W-1:0]      w_lat;

  function automatic logic [2:0] classify(input logic [FPU_OP_LEN-1:0] op);
    logic [31:0] v;
    v = 32'(op);
    if (v <= 32'h03)                       return C_ADD;
    else if (v <= 32'h05)                  return C_MUL;
    else if (v <= 32'h09)                  return C_ITER;
    else if (v >= 32'h10 && v <= 32'h21)   return C_SINGLE;
    else if (v >= 32'h22 && v <= 32'h27)   return C_CVT;
    else if (v == 32'h28 || v == 32'h29)   return C_SINGLE;
    else if (v >= 32'h30 && v <= 32'h33)   return C_MEM;
    else                                   return C_ILL;
  endfunction

  assign in_ready = ~rst & ~flush & ((r_state == S_IDLE) | ((r_state == S_WB) & wb_ready));

  always_comb begin
    w_class  = classify(in_op);
    w_accept = in_valid & in_ready;
    w_exec   = (w_class != C_MEM) && (w_class != C_ILL);
    w_lat    = '0;
    case (w_class)
      C_SINGLE: w_lat = CNT_W'(1);
      C_ADD:    w_lat = CNT_W'(ADD_LAT);
      C_MUL:    w_lat = CNT_W'(MUL_LAT);
      C_CVT:    w_lat = CNT_W'(CVT_LAT);
      default:  w_lat = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_rd      <= '0;
      r_fp      <= 1'b0;
      r_err     <= 1'b0;
      r_iter    <= 1'b0;
      r_start   <= 1'b0;
      r_kill    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_start   <= 1'b0;
      r_kill    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_EXEC: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_kill  <= 1'b1;
          end else if (r_iter) begin
            // r_start marks the start cycle, where a stale unit_done is ignored
            if (unit_done && !r_start) begin
              r_state <= S_WB;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
              r_state <= S_WB;
              r_err   <= 1'b1;
              r_kill  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else if (r_cnt == CNT_W'(1)) begin
            r_state <= S_WB;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_WB: begin
          if (flush || wb_ready) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
          end
        end
        S_IDLE: begin
        end
        default: r_state <= S_IDLE;
      endcase

      // Accepts happen from IDLE or a consumed WB; they override the exit to IDLE.
      if (w_accept) begin
        r_illegal <= (w_class == C_ILL);
        if (w_exec) begin
          r_state <= S_EXEC;
          r_op    <= in_op;
          r_rd    <= in_rd;
          r_fp    <= in_rd_fp;
          r_iter  <= (w_class == C_ITER);
          r_cnt   <= w_lat;
          r_start <= 1'b1;
          r_err   <= 1'b0;
        end
      end
    end
  end

  assign start    = r_start;
  assign start_op = r_op;
  assign kill     = r_kill;
  assign wb_valid = (r_state == S_WB);
  assign wb_rd    = r_rd;
  assign wb_fp    = r_fp;
  assign wb_err   = r_err;
  assign illegal  = r_illegal;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Bench for fpu_issue_seq: directed test-plan scenarios with literal checks,
// then randomized traffic compared every cycle against a timestamp-based model.
module tb_fpu_issue_seq;

  localparam int ADD_LAT = 3;
  localparam int MUL_LAT = 4;
  localparam int CVT_LAT = 2;
  localparam int TIMEOUT = 64;
  localparam int ITER_MARK = 1000;

  localparam int M_IDLE = 0;
  localparam int M_EXEC = 1;
  localparam int M_WB   = 2;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_op;
  logic [4:0] in_rd;
  logic       in_rd_fp;
  logic       flush;
  logic       start;
  logic [5:0] start_op;
  logic       unit_done;
  logic       kill;
  logic       wb_valid;
  logic       wb_ready;
  logic [4:0] wb_rd;
  logic       wb_fp;
  logic       wb_err;
  logic       illegal;
  logic       busy;

  fpu_issue_seq #(
    .FPU_OP_LEN(6), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT),
    .CVT_LAT(CVT_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rd_fp(in_rd_fp), .flush(flush),
    .start(start), .start_op(start_op), .unit_done(unit_done), .kill(kill),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_fp(wb_fp),
    .wb_err(wb_err), .illegal(illegal), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // EXEC length per op code: -1 illegal, 0 memory op, ITER_MARK for div/sqrt
  int lat_of [64];

  int         m_state;
  int         m_t;
  int         m_lat;
  logic [5:0] m_op;
  logic [4:0] m_rd;
  logic       m_fp;
  logic       m_err;
  logic       e_start;
  logic       e_kill;
  logic       e_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compare this cycle, advance the model with this cycle's inputs, then clock.
  task automatic tick();
    logic e_rdy;
    logic acc;
    int   k;
    logic n_start;
    logic n_kill;
    logic n_ill;
    #1;
    e_rdy = !rst && !flush && (m_state == M_IDLE || (m_state == M_WB && wb_ready));
    chk("in_ready", in_ready, e_rdy);
    chk("busy", busy, m_state != M_IDLE);
    chk("wb_valid", wb_valid, m_state == M_WB);
    chk("start", start, e_start);
    chk("kill", kill, e_kill);
    chk("illegal", illegal, e_ill);
    chk("start_op", start_op, m_op);
    chk("wb_rd", wb_rd, m_rd);
    chk("wb_fp", wb_fp, m_fp);
    if (m_state == M_WB) chk("wb_err", wb_err, m_err);

    n_start = 1'b0;
    n_kill  = 1'b0;
    n_ill   = 1'b0;
    if (rst) begin
      m_state = M_IDLE;
      m_op = '0; m_rd = '0; m_fp = 1'b0; m_err = 1'b0;
    end else begin
      acc = in_valid && e_rdy;
      if (m_state == M_EXEC) begin
        if (flush) begin
          m_state = M_IDLE;
          n_kill  = 1'b1;
        end else if (m_lat == ITER_MARK) begin
          if (unit_done && cyc > m_t + 1) begin
            m_state = M_WB; m_err = 1'b0;
          end else if (cyc == m_t + TIMEOUT) begin
            m_state = M_WB; m_err = 1'b1; n_kill = 1'b1;
          end
        end else if (cyc == m_t + m_lat) begin
          m_state = M_WB;
        end
      end else if (m_state == M_WB) begin
        if (flush || wb_ready) m_state = M_IDLE;
      end
      if (acc) begin
        k = lat_of[in_op];
        if (k < 0) n_ill = 1'b1;
        else if (k > 0) begin
          m_state = M_EXEC; m_t = cyc; m_lat = k;
          m_op = in_op; m_rd = in_rd; m_fp = in_rd_fp; m_err = 1'b0;
          n_start = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    e_start = n_start;
    e_kill  = n_kill;
    e_ill   = n_ill;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_op = '0; in_rd = '0; in_rd_fp = 1'b0;
    flush = 1'b0; unit_done = 1'b0; wb_ready = 1'b1;
  endtask

  task automatic offer(input logic [5:0] op, input logic [4:0] rd, input logic fp);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rd_fp = fp;
  endtask

  function automatic int pick_op();
    int singles2 [4] = '{32'h20, 32'h21, 32'h28, 32'h29};
    case ($urandom_range(0, 9))
      0: return int'($urandom_range(0, 3));
      1: return int'($urandom_range(4, 5));
      2: return int'($urandom_range(6, 9));
      3: return int'($urandom_range(16, 31));
      4: return singles2[$urandom_range(0, 3)];
      5: return int'($urandom_range(34, 39));
      6: return int'($urandom_range(48, 51));
      7: return 63;
      8: return int'($urandom_range(10, 15));
      default: return int'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    int kills;
    for (int i = 0; i < 64; i++) lat_of[i] = -1;
    for (int i = 0; i <= 3; i++) lat_of[i] = ADD_LAT;
    for (int i = 4; i <= 5; i++) lat_of[i] = MUL_LAT;
    for (int i = 6; i <= 9; i++) lat_of[i] = ITER_MARK;
    for (int i = 16; i <= 33; i++) lat_of[i] = 1;
    for (int i = 34; i <= 39; i++) lat_of[i] = CVT_LAT;
    lat_of[40] = 1;
    lat_of[41] = 1;
    for (int i = 48; i <= 51; i++) lat_of[i] = 0;

    m_state = M_IDLE; m_t = 0; m_lat = 0;
    m_op = '0; m_rd = '0; m_fp = 1'b0; m_err = 1'b0;
    e_start = 1'b0; e_kill = 1'b0; e_ill = 1'b0;

    idle_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", start, 0);
    chk("rst_kill", kill, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_err", wb_err, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_start_op", start_op, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_fp", wb_fp, 0);
    chk("rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    tick();

    // fadd.s: start at T+1, writeback at T+4, idle at T+5
    offer(6'h01, 5'd5, 1'b1); tick();
    idle_in();
    chk("fadd_start", start, 1);
    tick(); tick(); tick();
    chk("fadd_wb_valid", wb_valid, 1);
    chk("fadd_wb_rd", wb_rd, 5);
    chk("fadd_wb_fp", wb_fp, 1);
    tick();
    chk("fadd_idle", busy, 0);

    // feq.d then fmul.d accepted during the feq writeback
    offer(6'h14, 5'd9, 1'b0); tick();
    idle_in(); tick();
    chk("feq_wb_valid", wb_valid, 1);
    chk("feq_wb_rd", wb_rd, 9);
    chk("feq_wb_fp", wb_fp, 0);
    offer(6'h04, 5'd3, 1'b1);
    #1;
    chk("b2b_in_ready", in_ready, 1);
    tick();
    idle_in();
    chk("fmul_start", start, 1);
    chk("fmul_start_op", start_op, 6'h04);
    tick(); tick(); tick();
    chk("fmul_not_yet", wb_valid, 0);
    tick();
    chk("fmul_wb_valid", wb_valid, 1);
    chk("fmul_wb_rd", wb_rd, 3);
    tick();

    // fdiv.d: done in start cycle ignored, done at T+12 gives wb at T+13
    offer(6'h06, 5'd2, 1'b1); tick();
    idle_in(); unit_done = 1'b1; tick();
    unit_done = 1'b0;
    chk("fdiv_ign_wb", wb_valid, 0);
    chk("fdiv_ign_busy", busy, 1);
    repeat (10) tick();
    unit_done = 1'b1; tick();
    unit_done = 1'b0;
    chk("fdiv_wb_valid", wb_valid, 1);
    chk("fdiv_wb_err", wb_err, 0);
    tick();

    // fsqrt.s without unit_done: timeout writeback with one kill pulse
    offer(6'h09, 5'd4, 1'b1); wb_ready = 1'b0; tick();
    idle_in(); wb_ready = 1'b0;
    kills = 0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      #1;
      chk("tmo_in_ready", in_ready, 0);
      kills += int'(kill);
      tick();
    end
    chk("tmo_wb_valid", wb_valid, 1);
    chk("tmo_wb_err", wb_err, 1);
    chk("tmo_kill", kill, 1);
    kills += int'(kill);
    wb_ready = 1'b1; tick();
    kills += int'(kill);
    chk("tmo_kill_count", kills, 1);

    // fcvt with writeback back-pressure for 5 cycles
    offer(6'h22, 5'd7, 1'b1); wb_ready = 1'b0; tick();
    idle_in(); wb_ready = 1'b0; tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_wb_valid", wb_valid, 1);
      chk("bp_wb_rd", wb_rd, 7);
      chk("bp_wb_fp", wb_fp, 1);
      chk("bp_busy", busy, 1);
      #1;
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    wb_ready = 1'b1; tick();
    chk("bp_release_idle", busy, 0);

    // unmapped op 0x3F
    offer(6'h3F, 5'd1, 1'b0); tick();
    idle_in();
    chk("ill_pulse", illegal, 1);
    chk("ill_no_start", start, 0);
    tick();
    chk("ill_single", illegal, 0);

    // fsw: consumed silently
    offer(6'h33, 5'd1, 1'b0); tick();
    idle_in();
    chk("fsw_no_start", start, 0);
    chk("fsw_idle", busy, 0);
    tick();
    chk("fsw_no_wb", wb_valid, 0);

    // flush at T+2 of fmul.d
    offer(6'h05, 5'd6, 1'b1); tick();
    idle_in(); tick();
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("flush_kill", kill, 1);
    chk("flush_idle", busy, 0);
    for (int i = 0; i < 4; i++) begin
      chk("flush_no_wb", wb_valid, 0);
      tick();
    end

    // reset in the middle of EXEC
    offer(6'h04, 5'd12, 1'b1); tick();
    idle_in(); tick();
    rst = 1'b1; tick();
    chk("mrst_start", start, 0);
    chk("mrst_kill", kill, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_wb_valid", wb_valid, 0);
    chk("mrst_start_op", start_op, 0);
    chk("mrst_wb_rd", wb_rd, 0);
    chk("mrst_wb_fp", wb_fp, 0);
    #1;
    chk("mrst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    tick();

    // randomized traffic; the last part of each 1000-cycle block withholds unit_done
    for (int i = 0; i < 3000; i++) begin
      int op;
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 49) == 0);
      wb_ready  = ($urandom_range(0, 9) < 6);
      unit_done = ((i % 1000) < 600) ? ($urandom_range(0, 24) == 0) : 1'b0;
      in_valid  = ($urandom_range(0, 1) == 1);
      op        = pick_op();
      in_op     = op[5:0];
      in_rd     = 5'($urandom_range(0, 31));
      in_rd_fp  = ($urandom_range(0, 1) == 1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
